// File: rtl/rom_square_arbiter.sv
// ----------------------------------------------------------------------------
// rom_square_arbiter
//   Shares one synchronous ROM between C_N_REQ requesters. A round-robin
//   arbiter grants at most one request per cycle and drives the ROM address.
//   A C_RD_LATENCY-deep tag pipeline tracks which requester owns each read.
//   The tag routes the returning rom_rd_data to that requester.
//
// Ports
//   clk          : single clock for the block and the ROM
//   rst_n        : synchronous active-low reset
//   req_valid    : per-requester read request            [C_N_REQ]
//   req_addr     : per-requester address, slice i*AW+:AW [C_N_REQ*AW]
//   req_ready    : one-hot grant (or zero)                [C_N_REQ]
//   rsp_valid    : one-hot response strobe                [C_N_REQ]
//   rsp_data     : shared read-data bus (rom_rd_data)     [DW]
//   rom_addr     : ROM address pin                        [AW]
//   rom_rd_data  : ROM read-data pin                      [DW]
//   rom_rd_oce   : ROM output-register enable (latency 2 only)
//   rom_rst      : active-high ROM reset, registered from ~rst_n
// ----------------------------------------------------------------------------
module rom_square_arbiter #(
    parameter int unsigned C_ADDR_WIDTH = 10,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_N_REQ      = 4,
    parameter int unsigned C_RD_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_N_REQ-1:0]                req_valid,
    input  logic [C_N_REQ*C_ADDR_WIDTH-1:0]   req_addr,
    output logic [C_N_REQ-1:0]                req_ready,
    output logic [C_N_REQ-1:0]                rsp_valid,
    output logic [C_DATA_WIDTH-1:0]           rsp_data,
    output logic [C_ADDR_WIDTH-1:0]           rom_addr,
    input  logic [C_DATA_WIDTH-1:0]           rom_rd_data,
    output logic                              rom_rd_oce,
    output logic                              rom_rst
);

    localparam int unsigned PTR_W = (C_N_REQ > 1) ? $clog2(C_N_REQ) : 1;

    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_RD_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [PTR_W-1:0]        tag_id_q [C_RD_LATENCY];
    logic [PTR_W-1:0]        tag_id_d [C_RD_LATENCY];
    logic                    rom_rst_q;

    logic                    grant_any;
    logic [PTR_W-1:0]        grant_id;
    logic [C_ADDR_WIDTH-1:0] granted_addr;
    int unsigned             scan_idx;

    // Round-robin search starting at ptr_q, wrapping modulo C_N_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        if (rst_n) begin
            for (int unsigned k = 0; k < C_N_REQ; k++) begin
                scan_idx = k + 32'(ptr_q);
                if (scan_idx >= C_N_REQ) begin
                    scan_idx = scan_idx - C_N_REQ;
                end
                if (!grant_any && req_valid[scan_idx[PTR_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // The granted address goes straight to the ROM in the grant cycle.
    // Otherwise the ROM sees the last granted address.
    always_comb begin
        granted_addr = req_addr[32'(grant_id) * C_ADDR_WIDTH +: C_ADDR_WIDTH];
        rom_addr     = grant_any ? granted_addr : addr_q;
    end

    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        if (grant_any) begin
            ptr_d  = (grant_id == PTR_W'(C_N_REQ - 1)) ? '0 : grant_id + 1'b1;
            addr_d = granted_addr;
        end
    end

    // Stage 0 captures the acceptance; the last stage lines up with ROM data.
    always_comb begin
        tag_v_d[0]  = grant_any;
        tag_id_d[0] = grant_id;
        for (int unsigned s = 1; s < C_RD_LATENCY; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            addr_q  <= '0;
            tag_v_q <= '0;
            for (int unsigned s = 0; s < C_RD_LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            tag_v_q <= tag_v_d;
            for (int unsigned s = 0; s < C_RD_LATENCY; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        rom_rst_q <= ~rst_n;
    end

    assign rom_rst  = rom_rst_q;
    assign rsp_data = rom_rd_data;

    // Outputs are gated by rst_n so that a reset cycle never shows
    // a response for an in-flight request.
    always_comb begin
        rsp_valid = '0;
        if (rst_n && tag_v_q[C_RD_LATENCY-1]) begin
            rsp_valid[tag_id_q[C_RD_LATENCY-1]] = 1'b1;
        end
    end

    generate
        if (C_RD_LATENCY == 2) begin : g_oce
            assign rom_rd_oce = rst_n & tag_v_q[0];
        end else begin : g_no_oce
            assign rom_rd_oce = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rom_square_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rom_square_arbiter
//   Drives two arbiters with the same request stimulus. One arbiter has read
//   latency 2 and the other has read latency 1. Each arbiter has its own ROM
//   model with ROM[a] = a*3. Outputs are compared against a cycle-level
//   reference model. The model keeps a round-robin pointer and a queue of
//   pending responses, each with the cycle it is due.
// ----------------------------------------------------------------------------
module tb_rom_square_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;

    logic [N-1:0]  ready2, ready1, rsp2, rsp1;
    logic [DW-1:0] data2, data1, rd2, rd1;
    logic [AW-1:0] addr2, addr1;
    logic          oce2, oce1, romrst2, romrst1;

    always #5 clk = ~clk;

    rom_square_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_N_REQ(N), .C_RD_LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .rsp_valid(rsp2), .rsp_data(data2), .rom_addr(addr2),
        .rom_rd_data(rd2), .rom_rd_oce(oce2), .rom_rst(romrst2));

    rom_square_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_N_REQ(N), .C_RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rsp_valid(rsp1), .rsp_data(data1), .rom_addr(addr1),
        .rom_rd_data(rd1), .rom_rd_oce(oce1), .rom_rst(romrst1));

    // ROM models: L=2 uses an output register enabled by oce; L=1 reads directly.
    logic [DW-1:0] rom2_q1, rom2_q2, rom1_q;
    always @(posedge clk) begin
        rom2_q1 <= 32'(addr2) * 32'd3;
        if (oce2) rom2_q2 <= rom2_q1;
        rom1_q  <= 32'(addr1) * 32'd3;
    end
    assign rd2 = rom2_q2;
    assign rd1 = rom1_q;

    // ---------------- reference model ----------------
    typedef struct { int due; int id; int addr; } rsp_t;
    rsp_t qa[$];   // latency-2 responses
    rsp_t qb[$];   // latency-1 responses

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_ptr = 0;
    logic [AW-1:0] m_hold = '0;
    logic exp_rom_rst;

    int            e_gid;
    logic [N-1:0]  e_ready, e_rsp2, e_rsp1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data2, e_data1;
    logic          e_oce2;

    function automatic void compute_exp();
        e_gid   = -1;
        e_ready = '0;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (e_gid < 0 && req_valid[j]) e_gid = j;
            end
        end
        if (e_gid >= 0) e_ready[e_gid] = 1'b1;
        e_addr  = (e_gid >= 0) ? req_addr[e_gid*AW +: AW] : m_hold;
        e_rsp2  = '0; e_rsp1 = '0; e_data2 = '0; e_data1 = '0; e_oce2 = 1'b0;
        foreach (qa[n]) begin
            if (qa[n].due == cyc) begin e_rsp2[qa[n].id] = 1'b1; e_data2 = 32'(qa[n].addr * 3); end
            if (qa[n].due == cyc + 1) e_oce2 = 1'b1;
        end
        foreach (qb[n]) begin
            if (qb[n].due == cyc) begin e_rsp1[qb[n].id] = 1'b1; e_data1 = 32'(qb[n].addr * 3); end
        end
        if (rst_n !== 1'b1) begin e_rsp2 = '0; e_rsp1 = '0; e_oce2 = 1'b0; end
    endfunction

    // Advances the model across one rising edge, leaving time at the next falling edge.
    task automatic model_edge();
        compute_exp();
        @(posedge clk);
        cyc++;
        exp_rom_rst = !rst_n;
        if (!rst_n) begin
            qa.delete(); qb.delete(); m_ptr = 0; m_hold = '0;
        end else if (e_gid >= 0) begin
            qa.push_back('{cyc + 1, e_gid, int'(e_addr)});
            qb.push_back('{cyc, e_gid, int'(e_addr)});
            m_ptr  = (e_gid + 1) % N;
            m_hold = e_addr;
        end
        while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
        while (qb.size() > 0 && qb[0].due < cyc) void'(qb.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0;
        model_edge();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = N'($urandom);
            req_addr  = 40'({$urandom(), $urandom()});
            #1;
            checks++; if (ready2 !== '0 || ready1 !== '0) begin failures++; $display("FAIL reset_ready got=%b/%b exp=0000", ready2, ready1); end
            checks++; if (rsp2 !== '0 || rsp1 !== '0) begin failures++; $display("FAIL reset_rsp got=%b/%b exp=0000", rsp2, rsp1); end
            checks++; if (oce2 !== 1'b0) begin failures++; $display("FAIL reset_oce got=%b exp=0", oce2); end
            if (i > 0) begin
                checks++; if (romrst2 !== 1'b1 || romrst1 !== 1'b1) begin failures++; $display("FAIL reset_romrst got=%b/%b exp=1", romrst2, romrst1); end
                checks++; if (addr2 !== '0 || addr1 !== '0) begin failures++; $display("FAIL reset_addr got=%h/%h exp=0", addr2, addr1); end
            end
            model_edge();
        end
        rst_n = 1'b1; req_valid = '0;
        #1;
        checks++; if (romrst2 !== 1'b1) begin failures++; $display("FAIL release_romrst_hold got=%b exp=1", romrst2); end
        model_edge();
        #1;
        checks++; if (romrst2 !== 1'b0 || romrst1 !== 1'b0) begin failures++; $display("FAIL release_romrst got=%b/%b exp=0", romrst2, romrst1); end
    endtask

    task automatic test_single_read();
        req_valid = 4'b0001; req_addr = '0; req_addr[9:0] = 10'd5;
        #1;
        checks++; if (ready2 !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", ready2); end
        checks++; if (addr2 !== 10'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", addr2); end
        model_edge(); req_valid = '0;
        #1;
        checks++; if (rsp1 !== 4'b0001 || data1 !== 32'd15) begin failures++; $display("FAIL single_l1_rsp got=%b/%0d exp=0001/15", rsp1, data1); end
        checks++; if (rsp2 !== 4'b0000 || oce2 !== 1'b1 || oce1 !== 1'b0) begin failures++; $display("FAIL single_l2_early got=%b oce=%b/%b exp=0000 oce=1/0", rsp2, oce2, oce1); end
        model_edge();
        #1;
        checks++; if (rsp2 !== 4'b0001 || data2 !== 32'd15) begin failures++; $display("FAIL single_l2_rsp got=%b/%0d exp=0001/15", rsp2, data2); end
        checks++; if (rsp1 !== 4'b0000) begin failures++; $display("FAIL single_l1_once got=%b exp=0000", rsp1); end
        model_edge();
        #1;
        checks++; if (rsp2 !== 4'b0000) begin failures++; $display("FAIL single_l2_once got=%b exp=0000", rsp2); end
        model_edge();
    endtask

    task automatic test_all_valid();
        do_reset();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i * 7 + 1);
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 6) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 6) begin
                checks++; if (ready2 !== 4'(1 << (c % 4))) begin failures++; $display("FAIL allv_grant c=%0d got=%b exp=%b", c, ready2, 4'(1 << (c % 4))); end
            end else begin
                checks++; if (ready2 !== 4'b0000) begin failures++; $display("FAIL allv_idle c=%0d got=%b exp=0000", c, ready2); end
            end
            if (c >= 2) begin
                checks++;
                if (rsp2 !== 4'(1 << ((c - 2) % 4)) || data2 !== 32'((((c - 2) % 4) * 7 + 1) * 3)) begin
                    failures++; $display("FAIL allv_rsp2 c=%0d got=%b/%0d exp=%b/%0d", c, rsp2, data2, 4'(1 << ((c - 2) % 4)), (((c - 2) % 4) * 7 + 1) * 3);
                end
            end
            if (c >= 1 && c <= 6) begin
                checks++; if (rsp1 !== 4'(1 << ((c - 1) % 4))) begin failures++; $display("FAIL allv_rsp1 c=%0d got=%b exp=%b", c, rsp1, 4'(1 << ((c - 1) % 4))); end
            end
            model_edge();
        end
    endtask

    task automatic test_rr_skip();
        do_reset();
        req_addr = 40'({$urandom(), $urandom()});
        req_valid = 4'b0010; #1;
        checks++; if (ready2 !== 4'b0010) begin failures++; $display("FAIL rr_prime got=%b exp=0010", ready2); end
        model_edge();
        req_valid = 4'b1010; #1;
        checks++; if (ready2 !== 4'b1000) begin failures++; $display("FAIL rr_first got=%b exp=1000", ready2); end
        model_edge();
        req_valid = 4'b0010; #1;
        checks++; if (ready2 !== 4'b0010) begin failures++; $display("FAIL rr_second got=%b exp=0010", ready2); end
        model_edge();
        req_valid = 4'b1111; #1;
        checks++; if (ready2 !== 4'b0100) begin failures++; $display("FAIL rr_ptr2 got=%b exp=0100", ready2); end
        model_edge();
        req_valid = '0;
    endtask

    task automatic test_idle_hold();
        do_reset();
        req_valid = 4'b0100; req_addr[2*AW +: AW] = 10'h2A; #1;
        checks++; if (ready2 !== 4'b0100 || addr2 !== 10'h2A) begin failures++; $display("FAIL idle_grant got=%b/%h exp=0100/2a", ready2, addr2); end
        model_edge();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            req_addr = 40'({$urandom(), $urandom()}); #1;
            checks++; if (addr2 !== 10'h2A || addr1 !== 10'h2A || ready2 !== '0) begin failures++; $display("FAIL idle_hold c=%0d got=%h/%h rdy=%b exp=2a/2a rdy=0000", c, addr2, addr1, ready2); end
            model_edge();
        end
        req_valid = 4'b1111; #1;
        checks++; if (ready2 !== 4'b1000) begin failures++; $display("FAIL idle_ptr got=%b exp=1000", ready2); end
        model_edge();
        req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_addr = '0; req_addr[0 +: AW] = 10'd3; req_addr[AW +: AW] = 10'd4;
        req_valid = 4'b0011; #1;
        checks++; if (ready2 !== 4'b0001) begin failures++; $display("FAIL mid_acc0 got=%b exp=0001", ready2); end
        model_edge();
        req_valid = 4'b0010; #1;
        checks++; if (ready2 !== 4'b0010) begin failures++; $display("FAIL mid_acc1 got=%b exp=0010", ready2); end
        model_edge();
        req_valid = '0; rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (rsp2 !== '0 || oce2 !== 1'b0) begin failures++; $display("FAIL mid_flush c=%0d got=%b oce=%b exp=0000 oce=0", c, rsp2, oce2); end
            model_edge();
        end
        rst_n = 1'b1; req_valid = 4'b0100; req_addr[2*AW +: AW] = 10'd9; #1;
        checks++; if (ready2 !== 4'b0100 || ready1 !== 4'b0100) begin failures++; $display("FAIL mid_resume got=%b/%b exp=0100", ready2, ready1); end
        model_edge();
        req_valid = '0; #1;
        checks++; if (rsp2 !== '0) begin failures++; $display("FAIL mid_stale got=%b exp=0000", rsp2); end
        model_edge(); #1;
        checks++; if (rsp2 !== 4'b0100 || data2 !== 32'd27) begin failures++; $display("FAIL mid_new_rsp got=%b/%0d exp=0100/27", rsp2, data2); end
        model_edge();
    endtask

    task automatic test_random();
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            #1;
            compute_exp();
            checks++; if (ready2 !== e_ready || ready1 !== e_ready) begin failures++; $display("FAIL rand_ready c=%0d got=%b/%b exp=%b", c, ready2, ready1, e_ready); end
            checks++; if (addr2 !== e_addr || addr1 !== e_addr) begin failures++; $display("FAIL rand_addr c=%0d got=%h/%h exp=%h", c, addr2, addr1, e_addr); end
            checks++; if (rsp2 !== e_rsp2) begin failures++; $display("FAIL rand_rsp2 c=%0d got=%b exp=%b", c, rsp2, e_rsp2); end
            checks++; if (rsp1 !== e_rsp1) begin failures++; $display("FAIL rand_rsp1 c=%0d got=%b exp=%b", c, rsp1, e_rsp1); end
            if (e_rsp2 != '0) begin
                checks++; if (data2 !== e_data2) begin failures++; $display("FAIL rand_data2 c=%0d got=%h exp=%h", c, data2, e_data2); end
            end
            if (e_rsp1 != '0) begin
                checks++; if (data1 !== e_data1) begin failures++; $display("FAIL rand_data1 c=%0d got=%h exp=%h", c, data1, e_data1); end
            end
            checks++; if (oce2 !== e_oce2 || oce1 !== 1'b0) begin failures++; $display("FAIL rand_oce c=%0d got=%b/%b exp=%b/0", c, oce2, oce1, e_oce2); end
            checks++; if (romrst2 !== exp_rom_rst || romrst1 !== exp_rom_rst) begin failures++; $display("FAIL rand_romrst c=%0d got=%b/%b exp=%b", c, romrst2, romrst1, exp_rom_rst); end
            model_edge();
            if (e_gid >= 0) req_valid[e_gid] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 55) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0;
        test_reset();
        test_single_read();
        test_all_valid();
        test_rr_skip();
        test_idle_hold();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
